// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - locking round-robin arbiter driving a shared mux4 select
// Optional tenure limit enabled by defining MUX4_ARB_TIMEOUT_EN (uses MAX_HOLD).
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state, state_n;
  logic [3:0] gnt_n;
  logic [1:0] sel_n;
  logic [1:0] ptr, ptr_n;
  logic [2:0] pick;
  logic       rearb;

  // Returns {found, index}; the lowest offset from start wins because it is assigned last.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

`ifdef MUX4_ARB_TIMEOUT_EN
  localparam logic [15:0] HOLD_LAST = 16'(MAX_HOLD - 1);
  logic [15:0] hold_cnt;
  logic        new_grant;

  assign new_grant = (gnt_n != gnt) && (gnt_n != 4'b0000);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= 16'd0;
    end else if (new_grant) begin
      hold_cnt <= 16'd0;
    end else if (state == GRANT && hold_cnt != HOLD_LAST) begin
      hold_cnt <= hold_cnt + 16'd1;
    end
  end
`else
  logic unused_max_hold;
  assign unused_max_hold = |MAX_HOLD;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 4'b0000;
      sel   <= 2'd0;
      ptr   <= 2'd0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      sel   <= sel_n;
      ptr   <= ptr_n;
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    sel_n   = sel;
    ptr_n   = ptr;
    pick    = 3'b000;
    rearb   = 1'b0;
    case (state)
      IDLE: begin
        pick = rr_pick(req, ptr);
        if (pick[2]) begin
          state_n = GRANT;
          gnt_n   = 4'b0001 << pick[1:0];
          sel_n   = pick[1:0];
        end
      end
      GRANT: begin
        rearb = !req[sel];
`ifdef MUX4_ARB_TIMEOUT_EN
        if (hold_cnt == HOLD_LAST && (req & ~gnt) != 4'b0000) rearb = 1'b1;
`endif
        // Owner leaves: rotate past it and hand over on the same edge if anyone waits.
        if (rearb) begin
          ptr_n = sel + 2'd1;
          pick  = rr_pick(req & ~gnt, sel + 2'd1);
          if (pick[2]) begin
            gnt_n = 4'b0001 << pick[1:0];
            sel_n = pick[1:0];
          end else begin
            state_n = IDLE;
            gnt_n   = 4'b0000;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == GRANT);
  end

endmodule
